// File: rtl/regfile_pkg.sv
// Shared register-file definitions: sizes, the x0 index and the writeback request payload.
package regfile_pkg;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned NREG  = 8;
  localparam int unsigned AW    = $clog2(NREG);

  localparam logic [AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
  } wb_req_t;

  function automatic logic [NREG-1:0] reg_onehot(input logic [AW-1:0] a);
    return NREG'(1) << a;
  endfunction

endpackage

// File: rtl/wb_slot.sv
// One-entry writeback holding slot; tracks whether it is younger than its peer slot.
module wb_slot
  import regfile_pkg::*;
(
  input  logic    clk,
  input  logic    rst_i,
  input  logic    load_i,
  input  logic    clear_i,
  input  logic    peer_full_i,
  input  logic    peer_clear_i,
  input  wb_req_t req_i,
  output logic    full_o,
  output logic    young_o,
  output logic    ready_o,
  output wb_req_t req_o
);

  logic    full_q, full_d;
  logic    young_q, young_d;
  wb_req_t req_q;

  // Younger only if the peer still holds an entry after this edge; peer draining makes us oldest.
  always_comb begin
    full_d  = load_i | (full_q & ~clear_i);
    young_d = load_i ? (peer_full_i & ~peer_clear_i)
                     : (young_q & ~peer_clear_i & ~clear_i);
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      full_q  <= 1'b0;
      young_q <= 1'b0;
    end else begin
      full_q  <= full_d;
      young_q <= young_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load_i) req_q <= req_i;
  end

  assign full_o  = full_q;
  assign young_o = young_q;
  assign ready_o = ~full_q | clear_i;
  assign req_o   = req_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates two writeback requesters onto the single register-file write port, oldest-first.
// Optional read bypass from the holding slots is enabled by defining WB_BYPASS_EN.
module regfile_wb_arbiter
  import regfile_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [AW-1:0]    req0_addr,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [AW-1:0]    req1_addr,
  input  logic [WIDTH-1:0] req1_data,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [WIDTH-1:0] wr_data,
  output logic [NREG-1:0]  pending_mask,
  input  logic [AW-1:0]    rd_addr1,
  input  logic [AW-1:0]    rd_addr2,
  input  logic [WIDTH-1:0] rf_rd_data1,
  input  logic [WIDTH-1:0] rf_rd_data2,
  output logic [WIDTH-1:0] rd_data1,
  output logic [WIDTH-1:0] rd_data2
);

  logic [1:0] valid, ready, load, full, young, gnt;
  logic       tie;
  logic       rr_q, rr_d;
  wb_req_t    req_in   [2];
  wb_req_t    slot_req [2];
  wb_req_t    wr_req;

  assign valid     = {req1_valid, req0_valid};
  assign req_in[0] = '{addr: req0_addr, data: req0_data};
  assign req_in[1] = '{addr: req1_addr, data: req1_data};
  assign load      = valid & ready;

  for (genvar k = 0; k < 2; k++) begin : g_slot
    wb_slot u_slot (
      .clk          (clk),
      .rst_i        (rst_n),
      .load_i       (load[k]),
      .clear_i      (gnt[k]),
      .peer_full_i  (full[1-k]),
      .peer_clear_i (gnt[1-k]),
      .req_i        (req_in[k]),
      .full_o       (full[k]),
      .young_o      (young[k]),
      .ready_o      (ready[k]),
      .req_o        (slot_req[k])
    );
  end

  // Grant: lone full slot, else the older one, else the round-robin pointer.
  always_comb begin
    gnt = 2'b00;
    tie = 1'b0;
    case (full)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11: begin
        if (young[0] == young[1]) begin
          tie = 1'b1;
          gnt = rr_q ? 2'b10 : 2'b01;
        end else begin
          gnt = young[0] ? 2'b10 : 2'b01;
        end
      end
      default: gnt = 2'b00;
    endcase
    rr_d = tie ? ~rr_q : rr_q;
  end

  always_ff @(posedge clk) begin
    if (rst_n) rr_q <= 1'b0;
    else       rr_q <= rr_d;
  end

  // Strobe is held off during reset so buffered writes are discarded, not committed.
  assign wr_req     = slot_req[gnt[1]];
  assign wr_addr    = wr_req.addr;
  assign wr_data    = wr_req.data;
  assign wr_en      = (|gnt) & (wr_req.addr != REG_ZERO) & ~rst_n;
  assign req0_ready = ready[0];
  assign req1_ready = ready[1];

  always_comb begin
    pending_mask = '0;
    for (int k = 0; k < 2; k++) begin
      if (full[k]) pending_mask = pending_mask | reg_onehot(slot_req[k].addr);
    end
    pending_mask[0] = 1'b0;
  end

`ifdef WB_BYPASS_EN
  logic last_slot;

  // Slot whose write lands last when both hold the same register.
  assign last_slot = (young[0] != young[1]) ? young[1] : ~rr_q;

  function automatic logic [WIDTH-1:0] fwd(input logic [AW-1:0] ra, input logic [WIDTH-1:0] rfd,
                                           input logic [1:0] f, input wb_req_t s0, input wb_req_t s1,
                                           input logic last);
    logic h0, h1;
    h0 = f[0] && (s0.addr == ra);
    h1 = f[1] && (s1.addr == ra);
    if (ra == REG_ZERO) return rfd;
    if (h0 && h1)       return last ? s1.data : s0.data;
    if (h1)             return s1.data;
    if (h0)             return s0.data;
    return rfd;
  endfunction

  assign rd_data1 = fwd(rd_addr1, rf_rd_data1, full, slot_req[0], slot_req[1], last_slot);
  assign rd_data2 = fwd(rd_addr2, rf_rd_data2, full, slot_req[0], slot_req[1], last_slot);
`else
  logic unused_rd;

  assign unused_rd = ^{rd_addr1, rd_addr2};
  assign rd_data1  = rf_rd_data1;
  assign rd_data2  = rf_rd_data2;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: cycle table, write scoreboard, and reset/same-address sequences.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic             req0_ready, req1_ready;
  logic [AW-1:0]    req0_addr = '0, req1_addr = '0;
  logic [WIDTH-1:0] req0_data = '0, req1_data = '0;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [NREG-1:0]  pending_mask;
  logic [AW-1:0]    rd_addr1 = '0, rd_addr2 = '0;
  logic [WIDTH-1:0] rf_rd_data1, rf_rd_data2, rd_data1, rd_data2;

  logic [WIDTH-1:0] rf [NREG] = '{default: '0};

  int n_vec = 0;
  int n_err = 0;
  wb_req_t exp_q [$];

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .pending_mask(pending_mask),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2),
    .rd_data1(rd_data1), .rd_data2(rd_data2)
  );

  // Register file behind the write port.
  always @(posedge clk) if (wr_en) rf[wr_addr] <= wr_data;
  assign rf_rd_data1 = rf[rd_addr1];
  assign rf_rd_data2 = rf[rd_addr2];

  // Scoreboard: every strobe must match the next predicted write.
  always @(negedge clk) begin
    wb_req_t e;
    if (wr_en) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_write: got unexpected write r%0d=%h, required no write", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        if (wr_addr !== e.addr || wr_data !== e.data) begin
          n_err++;
          $display("FAIL sb_write: got r%0d=%h, required r%0d=%h", wr_addr, wr_data, e.addr, e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, got, expv);
    end
  endtask

  function automatic logic [31:0] status();
    return 32'({wr_en, pending_mask, req0_ready, req1_ready});
  endfunction

  function automatic logic [31:0] st(input int we, input int mask, input int r0, input int r1);
    return 32'({1'(we), NREG'(mask), 1'(r0), 1'(r1)});
  endfunction

  typedef struct {
    logic             v0;
    logic [AW-1:0]    a0;
    logic [WIDTH-1:0] d0;
    logic             v1;
    logic [AW-1:0]    a1;
    logic [WIDTH-1:0] d1;
    logic             wen;
    logic [AW-1:0]    wa;
    logic [WIDTH-1:0] wd;
    logic [NREG-1:0]  mask;
    logic             rdy0, rdy1;
  } vec_t;

  function automatic vec_t mk(input int v0, a0, d0, v1, a1, d1, wen, wa, wd, mask, r0, r1);
    vec_t r;
    r.v0 = 1'(v0); r.a0 = AW'(a0); r.d0 = WIDTH'(d0);
    r.v1 = 1'(v1); r.a1 = AW'(a1); r.d1 = WIDTH'(d1);
    r.wen = 1'(wen); r.wa = AW'(wa); r.wd = WIDTH'(wd);
    r.mask = NREG'(mask); r.rdy0 = 1'(r0); r.rdy1 = 1'(r1);
    return r;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
  endtask

  vec_t tbl [20];

  initial begin
    // Inputs driven this cycle | outputs observed this cycle (write, mask, ready0, ready1).
    tbl[0]  = mk(1, 3, 'hA, 0, 0, 0,   0, 0, 0,   'h00, 1, 1);
    tbl[1]  = mk(0, 0, 0,   0, 0, 0,   1, 3, 'hA, 'h08, 1, 1);
    tbl[2]  = mk(1, 2, 5,   1, 4, 6,   0, 0, 0,   'h00, 1, 1);
    tbl[3]  = mk(0, 0, 0,   0, 0, 0,   1, 2, 5,   'h14, 1, 0);
    tbl[4]  = mk(0, 0, 0,   0, 0, 0,   1, 4, 6,   'h10, 1, 1);
    tbl[5]  = mk(0, 0, 0,   1, 0, 'hF, 0, 0, 0,   'h00, 1, 1);
    tbl[6]  = mk(0, 0, 0,   0, 0, 0,   0, 0, 0,   'h00, 1, 1);
    tbl[7]  = mk(1, 1, 7,   1, 6, 9,   0, 0, 0,   'h00, 1, 1);
    tbl[8]  = mk(1, 5, 3,   0, 0, 0,   1, 6, 9,   'h42, 0, 1);
    tbl[9]  = mk(1, 5, 3,   1, 7, 2,   1, 1, 7,   'h02, 1, 1);
    tbl[10] = mk(0, 0, 0,   0, 0, 0,   1, 5, 3,   'hA0, 1, 0);
    tbl[11] = mk(1, 2, 4,   0, 0, 0,   1, 7, 2,   'h80, 1, 1);
    tbl[12] = mk(0, 0, 0,   1, 3, 1,   1, 2, 4,   'h04, 1, 1);
    tbl[13] = mk(0, 0, 0,   0, 0, 0,   1, 3, 1,   'h08, 1, 1);
    tbl[14] = mk(1, 1, 8,   1, 6, 'hC, 0, 0, 0,   'h00, 1, 1);
    tbl[15] = mk(0, 0, 0,   1, 7, 'hE, 1, 6, 'hC, 'h42, 0, 1);
    tbl[16] = mk(1, 4, 5,   0, 0, 0,   1, 1, 8,   'h82, 1, 0);
    tbl[17] = mk(0, 0, 0,   0, 0, 0,   1, 7, 'hE, 'h90, 0, 1);
    tbl[18] = mk(0, 0, 0,   0, 0, 0,   1, 4, 5,   'h10, 1, 1);
    tbl[19] = mk(0, 0, 0,   0, 0, 0,   0, 0, 0,   'h00, 1, 1);

    // Power-on reset.
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("reset_state", status(), st(0, 'h00, 1, 1));

    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      req0_valid = tbl[i].v0; req0_addr = tbl[i].a0; req0_data = tbl[i].d0;
      req1_valid = tbl[i].v1; req1_addr = tbl[i].a1; req1_data = tbl[i].d1;
      if (tbl[i].wen) exp_q.push_back('{addr: tbl[i].wa, data: tbl[i].wd});
      @(negedge clk);
      chk($sformatf("tbl_row%0d", i), status(),
          32'({tbl[i].wen, tbl[i].mask, tbl[i].rdy0, tbl[i].rdy1}));
    end

    // Same register from both requesters: younger (tie -> slot after rr_ptr) must land last.
    do_reset();
    @(posedge clk); #1;
    rd_addr1 = 3'd5; rd_addr2 = 3'd3;
    req0_valid = 1'b1; req0_addr = 3'd5; req0_data = 4'h1;
    req1_valid = 1'b1; req1_addr = 3'd5; req1_data = 4'h2;
    exp_q.push_back('{addr: 3'd5, data: 4'h1});
    exp_q.push_back('{addr: 3'd5, data: 4'h2});
    @(negedge clk);
    chk("same_addr_rd1_c0", 32'(rd_data1), 32'h3);
    chk("rd2_passthru", 32'(rd_data2), 32'h1);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    chk("same_addr_mask", 32'(pending_mask), 32'h20);
    chk("same_addr_rd1_c1", 32'(rd_data1), BYP ? 32'h2 : 32'h3);
    @(posedge clk);
    @(negedge clk);
    chk("same_addr_rd1_c2", 32'(rd_data1), BYP ? 32'h2 : 32'h1);
    @(posedge clk);
    @(negedge clk);
    chk("same_addr_rd1_c3", 32'(rd_data1), 32'h2);
    chk("same_addr_rf5", 32'(rf[5]), 32'h2);

    // Reset with both slots full: nothing reaches the register file.
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_addr = 3'd6; req0_data = 4'hF;
    req1_valid = 1'b1; req1_addr = 3'd3; req1_data = 4'hF;
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midreset_wr_en", 32'(wr_en), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_after", status(), st(0, 'h00, 1, 1));
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midreset_rf6", 32'(rf[6]), 32'hC);
    chk("midreset_rf3", 32'(rf[3]), 32'h1);
    chk("sb_drained", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion, required completion before 100000");
    $fatal(1);
  end

endmodule
